keypad_emulator: RTL and testbench
==================================

Name: keypad_emulator

Overview:
- Behavioural-in-silicon model of a 4x4 matrix keypad; the responder end of the row-drive/column-sense keypad interface.
- Accepts queued key-press requests and, for each, closes one row/column "contact" for a programmed hold time, then opens it for a programmed gap.
- Sits on the FPGA between the keypad scanner's row drive and its column inputs, for self-test and for hardware-in-loop testing without a physical keypad.

Parameters:
- HOLD_CYCLES, 64, clock cycles the contact stays closed per key; legal range >=2.
- GAP_CYCLES, 32, clock cycles the contact stays open after release; legal range >=1.
- FIFO_DEPTH, 4, number of queued key requests; power of 2, >=2.
- BOUNCE_CYCLES, 8, bounce window length, used only with the optional feature; must be < HOLD_CYCLES and < GAP_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- key_valid  in  1  request-valid strobe for key_code
- key_code  in  4  key to press: [3:2] = row index, [1:0] = column index
- key_ready  out  1  request FIFO can accept
- rowScan  in  4  row drive from scanner; bit r high = row r driven
- col  out  4  column sense to scanner; bit c high = contact closed on a driven row
- busy  out  1  FIFO non-empty or FSM not IDLE
- done  out  1  one-cycle pulse marking the end of a key's gap
- active_key  out  4  key_code currently held; 0 when IDLE

Behaviour:
- Clock and reset: one clock domain (clk). reset is asynchronous and active-high.
- Reset values: FSM = IDLE, FIFO empty, counter = 0, key_ready = 1, busy = 0, done = 0, active_key = 0, col = 0.
- Handshake:
  - A request is accepted on any edge where key_valid && key_ready.
  - key_ready = !fifo_full.
  - Request order is preserved.
  - key_code must stay stable while key_valid is high and key_ready is low.
- FSM states: IDLE, PRESS, RELEASE. A single up-counter cnt is shared.
  - IDLE: if the FIFO is non-empty, pop the head into active_key, set cnt = 0, go to PRESS. Otherwise stay in IDLE.
  - PRESS: cnt increments each cycle. When cnt == HOLD_CYCLES-1, set cnt = 0 and go to RELEASE.
  - RELEASE: cnt increments each cycle. When cnt == GAP_CYCLES-1, go to IDLE, with done = 1 in that final RELEASE cycle (registered output).
- Latency:
  - A request accepted on edge E into an empty FIFO with the FSM in IDLE enters PRESS on edge E+1.
  - col is closed for exactly HOLD_CYCLES cycles, then open for GAP_CYCLES cycles.
  - done is high in the cycle beginning at edge E+HOLD_CYCLES+GAP_CYCLES.
  - Back-to-back keys always see exactly one IDLE cycle between a RELEASE and the next PRESS.
- Contact = (state == PRESS).
- Column output (combinational from rowScan and registered state; zero-cycle latency):
  - col[c] = contact && (c == active_key[1:0]) && rowScan[active_key[3:2]].
  - All other col bits are 0.
  - col follows rowScan within the same cycle, including when multiple or all rows are driven.
- Simultaneous push and pop: allowed when the FIFO is non-full. Occupancy is unchanged.
- Full FIFO: key_ready is low and the request is held off, never dropped.
- Reset mid-operation: col drops to 0 immediately (asynchronously) and the queue is flushed.
- active_key is cleared to 0 on entry to IDLE.
- busy = (state != IDLE) || !fifo_empty.

Optional Feature:
- Macro: KEYPAD_EMULATOR_BOUNCE_EN.
- Defined: contact bounce is modelled.
  - During PRESS with cnt < BOUNCE_CYCLES, contact = ~cnt[0] (closed, open, closed, ...).
  - During RELEASE with cnt < BOUNCE_CYCLES, contact = cnt[0] (open, closed, open, ...).
  - Otherwise contact is as in the base behaviour.
  - FSM timing and done timing are unchanged.
- Undefined: contact = (state == PRESS) exactly. BOUNCE_CYCLES is ignored.

Test Plan:
- Single press: key_code = 4'h6 accepted at edge E, rowScan = 4'b0010 held -> col = 4'b0100 from E+1 through E+64; col = 0 from E+65; done = 1 only in cycle E+96; busy falls after done.
- Row gating: during the PRESS of key 4'h6, step rowScan through 0001, 0100, 1000, then 1111 -> col = 0000, 0000, 0000, then 0100, each in the same cycle as the rowScan change.
- Queue/backpressure: hold key_valid high with codes 0, 5, A, F, 3, C back-to-back from IDLE -> key_ready drops after the FIFO holds 4; all 6 are eventually pressed in order; active_key sequence = 0, 5, A, F, 3, C; one IDLE cycle between consecutive presses.
- Reset mid-PRESS: assert reset at cycle 20 of a hold with 2 keys queued -> col = 0 immediately; after release of reset, key_ready = 1, busy = 0, no further presses.
- Boundary parameters: HOLD_CYCLES = 2, GAP_CYCLES = 1, key 4'h0, rowScan = 1111 -> col = 0001 for exactly 2 cycles; done in the following cycle.
- With KEYPAD_EMULATOR_BOUNCE_EN, key 4'h9, rowScan = 1111 -> col[1] pattern 1,0,1,0,1,0,1,0 then 1 for 56 cycles; in RELEASE 0,1,0,1,0,1,0,1 then 0 for 24 cycles; done at the same cycle as without the macro.

Source files
------------

// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - 4x4 matrix keypad responder driven by a queue of key requests
// Optional contact bounce model: define KEYPAD_EMULATOR_BOUNCE_EN.
module keypad_emulator #(
  parameter int HOLD_CYCLES   = 64,
  parameter int GAP_CYCLES    = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int BOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  input  logic [3:0] rowScan,
  output logic [3:0] col,
  output logic       busy,
  output logic       done,
  output logic [3:0] active_key
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
  localparam bit BOUNCE_EN = 1'b1;
`else
  localparam bit BOUNCE_EN = 1'b0;
`endif
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS, RELEASE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;

  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          fifo_empty, fifo_full, push, pop;
  logic [3:0]    fifo_head;
  logic          contact, in_bounce;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign key_ready  = !fifo_full;
  assign push       = key_valid && !fifo_full;
  assign pop        = (state == IDLE) && !fifo_empty;
  assign fifo_head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= key_code;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_next = PRESS;
          cnt_next   = '0;
        end
      end
      PRESS: begin
        if (cnt == HOLD_LAST) begin
          state_next = RELEASE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (cnt == GAP_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // done is registered, so it is decided from where the FSM lands next.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      done       <= 1'b0;
      active_key <= '0;
    end else begin
      cnt  <= cnt_next;
      done <= (state_next == RELEASE) && (cnt_next == GAP_LAST);
      if (pop)
        active_key <= fifo_head;
      else if (state_next == IDLE)
        active_key <= '0;
    end
  end

  always_comb begin
    in_bounce = BOUNCE_EN && (32'(cnt) < BOUNCE_CYCLES);
    contact   = 1'b0;
    case (state)
      PRESS:   contact = in_bounce ? ~cnt[0] : 1'b1;
      RELEASE: contact = in_bounce ?  cnt[0] : 1'b0;
      default: contact = 1'b0;
    endcase
    col = '0;
    if (contact && rowScan[active_key[3:2]])
      col[active_key[1:0]] = 1'b1;
    busy = (state != IDLE) || !fifo_empty;
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// tb/tb_keypad_emulator.sv - self-checking bench for keypad_emulator
module tb_keypad_emulator;
  localparam int H = 64, G = 32, D = 4, B = 8;
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
  localparam bit BOUNCE_EN = 1'b1;
`else
  localparam bit BOUNCE_EN = 1'b0;
`endif

  logic       clk = 1'b0, reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [3:0] rowScan = 4'b0010;
  logic       key_ready, busy, done;
  logic [3:0] col, active_key;

  logic       b_valid = 1'b0;
  logic [3:0] b_code = 4'h0;
  logic [3:0] b_rowscan = 4'b1111;
  logic       b_ready, b_busy, b_done;
  logic [3:0] b_col, b_active;

  int n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;

  keypad_emulator #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .FIFO_DEPTH(D), .BOUNCE_CYCLES(B)) u_dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .rowScan(rowScan), .col(col), .busy(busy),
    .done(done), .active_key(active_key)
  );

  keypad_emulator #(.HOLD_CYCLES(2), .GAP_CYCLES(1), .FIFO_DEPTH(2), .BOUNCE_CYCLES(0)) u_bnd (
    .clk(clk), .reset(reset), .key_valid(b_valid), .key_code(b_code),
    .key_ready(b_ready), .rowScan(b_rowscan), .col(b_col), .busy(b_busy),
    .done(b_done), .active_key(b_active)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each accepted key k has an accept edge and a press-start edge; every
  // output for cycle t follows from where t falls relative to those edges.
  int         m_acc[$];
  int         m_st[$];
  logic [3:0] m_code[$];

  initial begin
    int t, occ, act_k, p, last_st, st;
    logic       e_ready, e_busy, e_done, ct;
    logic [3:0] e_active, e_col;
    t = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_acc.delete(); m_st.delete(); m_code.delete();
        t = 0;
      end else begin
        occ = 0; act_k = -1;
        foreach (m_acc[k]) begin
          if (m_acc[k] <= t && t < m_st[k]) occ++;
          if (m_st[k] <= t && t < m_st[k] + H + G) act_k = k;
        end
        e_ready = (occ < D);
        e_busy = (act_k >= 0) || (occ > 0);
        e_done = 1'b0; e_active = 4'h0; e_col = 4'h0;
        if (act_k >= 0) begin
          p = t - m_st[act_k];
          e_active = m_code[act_k];
          e_done = (p == H + G - 1);
          if (p < H) ct = (BOUNCE_EN && p < B) ? (p % 2 == 0) : 1'b1;
          else       ct = BOUNCE_EN && (p - H) < B && ((p - H) % 2 == 1);
          if (ct && rowScan[e_active[3:2]]) e_col = 4'b0001 << e_active[1:0];
        end
        chk("m_key_ready", key_ready, e_ready);
        chk("m_busy", busy, e_busy);
        chk("m_done", done, e_done);
        chk("m_active_key", active_key, e_active);
        chk("m_col", col, e_col);
        if (key_valid && e_ready) begin
          last_st = (m_st.size() > 0) ? m_st[m_st.size()-1] : -1000;
          st = (t + 2 > last_st + H + G + 1) ? t + 2 : last_st + H + G + 1;
          m_acc.push_back(t + 1);
          m_st.push_back(st);
          m_code.push_back(key_code);
        end
        t++;
      end
    end
  end

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < lim);
    chk("idle_timeout", busy, 1'b0);
  endtask

  logic [3:0] rg_scan [4] = '{4'b0001, 4'b0100, 4'b1000, 4'b1111};
  logic [3:0] rg_exp  [4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100};
  logic [3:0] qcodes  [6] = '{4'h0, 4'h5, 4'hA, 4'hF, 4'h3, 4'hC};

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rowScan = 4'b1111;
    #1;
    chk("rst_key_ready", key_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_active_key", active_key, 4'h0);
    chk("rst_col", col, 4'h0);
    rowScan = 4'b0010;
    @(posedge clk); #1; reset = 1'b0;

    // single press of key 6 on row 1
    @(posedge clk); #1; key_code = 4'h6; key_valid = 1'b1;
    @(posedge clk); #1; key_valid = 1'b0;
    @(negedge clk);
    chk("sp_col_E", col, 4'h0);
    chk("sp_busy_E", busy, 1'b1);
    @(negedge clk);
    chk("sp_col_E1", col, 4'b0100);
    chk("sp_active_E1", active_key, 4'h6);
    repeat (63) @(negedge clk);
    chk("sp_col_E64", col, 4'b0100);
    @(negedge clk);
    chk("sp_col_E65", col, 4'h0);
    repeat (30) @(negedge clk);
    chk("sp_done_E95", done, 1'b0);
    @(negedge clk);
    chk("sp_done_E96", done, 1'b1);
    @(negedge clk);
    chk("sp_done_E97", done, 1'b0);
    chk("sp_busy_E97", busy, 1'b0);

    // row gating inside a press
    @(posedge clk); #1; key_code = 4'h6; key_valid = 1'b1;
    @(posedge clk); #1; key_valid = 1'b0;
    repeat (20) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1; rowScan = rg_scan[i];
      @(negedge clk);
      chk("rg_col", col, rg_exp[i]);
      @(posedge clk);
    end
    #1; rowScan = 4'b0010;
    wait_idle(300);

    // queue and backpressure
    @(posedge clk); #1; rowScan = 4'b1111; key_code = qcodes[0]; key_valid = 1'b1;
    fork
      begin
        int i;
        logic rdy;
        i = 0;
        while (i < 6) begin
          @(negedge clk); rdy = key_ready;
          @(posedge clk); #1;
          if (rdy) begin
            i++;
            if (i < 6) key_code = qcodes[i];
            else       key_valid = 1'b0;
          end
        end
      end
      begin
        int k;
        @(posedge clk);
        for (int c = 0; c <= 1 + 97 * 5 + 1; c++) begin
          @(negedge clk);
          if (c == 3) chk("q_ready_c3", key_ready, 1'b1);
          if (c == 4) chk("q_full_c4", key_ready, 1'b0);
          if (c >= 1 && (c - 1) % 97 == 0 && (c - 1) / 97 < 6) begin
            k = (c - 1) / 97;
            chk("q_active", active_key, qcodes[k]);
            chk("q_col", col, 4'b0001 << qcodes[k][1:0]);
          end
          if (c >= 97 && c % 97 == 0 && c / 97 < 6) begin
            chk("q_gap_active", active_key, 4'h0);
            chk("q_gap_col", col, 4'h0);
          end
        end
      end
    join
    wait_idle(800);

    // reset in the middle of a hold with two keys queued
    @(posedge clk); #1; key_code = 4'h9; key_valid = 1'b1;
    @(posedge clk); #1; key_code = 4'h2;
    @(posedge clk); #1; key_code = 4'hB;
    @(posedge clk); #1; key_valid = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk); #1;
    chk("mr_col_before", col, 4'b0010);
    reset = 1'b1;
    #1;
    chk("mr_col_async", col, 4'h0);
    chk("mr_busy", busy, 1'b0);
    chk("mr_key_ready", key_ready, 1'b1);
    @(posedge clk); @(posedge clk); #1; reset = 1'b0;
    repeat (150) @(negedge clk);
    chk("mr_busy_after", busy, 1'b0);
    chk("mr_active_after", active_key, 4'h0);

    // minimum hold/gap instance
    @(posedge clk); #1; b_code = 4'h0; b_valid = 1'b1;
    @(posedge clk); #1; b_valid = 1'b0;
    @(negedge clk);
    chk("bd_col_E", b_col, 4'h0);
    @(negedge clk);
    chk("bd_col_E1", b_col, 4'b0001);
    @(negedge clk);
    chk("bd_col_E2", b_col, 4'b0001);
    chk("bd_done_E2", b_done, 1'b0);
    @(negedge clk);
    chk("bd_col_E3", b_col, 4'h0);
    chk("bd_done_E3", b_done, 1'b1);
    @(negedge clk);
    chk("bd_done_E4", b_done, 1'b0);
    chk("bd_busy_E4", b_busy, 1'b0);
    chk("bd_ready_E4", b_ready, 1'b1);
    chk("bd_active_E4", b_active, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
